// File: rtl/bcd_to_binary_seq_if.sv
// Handshake and data bundle for the sequential BCD-to-binary converter.
// The requester drives start and the three digits; the converter returns status and result.
interface bcd_to_binary_seq_if;
    logic       start;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic       busy;
    logic       done;
    logic       err;
    logic [9:0] bin;
    logic       bin_ovf;

    modport master (
        output start, ones, tens, hundreds,
        input  busy, done, err, bin, bin_ovf
    );

    modport slave (
        input  start, ones, tens, hundreds,
        output busy, done, err, bin, bin_ovf
    );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Three-digit BCD to 10-bit binary converter using a reverse double-dabble engine:
// shift right, then subtract 3 from any BCD nibble >= 8, repeated 10 times.
//
// state | meaning
// IDLE  | waiting for start; digits sampled on the accepting edge
// SHIFT | ten shift/correct iterations in progress
// DONE  | one-cycle done pulse; result or error already registered
module bcd_to_binary_seq (
    input  logic             clk,
    input  logic             rst_n,
    bcd_to_binary_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_SHIFT = 4'd9;

    state_t      state_q, state_d;
    logic [21:0] work_q, work_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [9:0]  bin_q, bin_d;
    logic        bin_ovf_q, bin_ovf_d;

    logic        digits_ok;
    logic [21:0] work_shifted;

    // One iteration: shift right, then correct each BCD nibble on its own (no borrow between nibbles).
    function automatic logic [21:0] dabble_step(input logic [21:0] w);
        logic [21:0] s;
        s = w >> 1;
        for (int n = 0; n < 3; n++) begin
            if (s[10 + 4*n +: 4] >= 4'd8) begin
                s[10 + 4*n +: 4] = s[10 + 4*n +: 4] - 4'd3;
            end
        end
        return s;
    endfunction

    assign digits_ok    = (bus.ones <= 4'd9) && (bus.tens <= 4'd9) && (bus.hundreds <= 4'd9);
    assign work_shifted = dabble_step(work_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bin_q     <= '0;
            bin_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            bin_q     <= bin_d;
            bin_ovf_q <= bin_ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = digits_ok ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_SHIFT) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // busy/done are computed from the next state so both leave the block registered.
    always_comb begin
        work_d    = work_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        bin_d     = bin_q;
        bin_ovf_d = bin_ovf_q;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (digits_ok) begin
                        work_d = {bus.hundreds, bus.tens, bus.ones, 10'b0};
                        cnt_d  = '0;
                        err_d  = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                work_d = work_shifted;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == LAST_SHIFT) begin
                    bin_d     = work_shifted[9:0];
                    bin_ovf_d = (work_shifted[9:0] > 10'd255);
                end
            end
            default: ;
        endcase
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.bin     = bin_q;
    assign bus.bin_ovf = bin_ovf_q;

    // For legal digits every BCD nibble has been drained by the final shift.
    a_bcd_drained : assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == SHIFT && cnt_q == LAST_SHIFT) |-> (work_shifted[21:10] == 12'd0)
    );

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed cases, exhaustive sweep and random
// requests, all compared against a decimal-arithmetic reference model.
module tb_bcd_to_binary_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_to_binary_seq_if bus ();

    bcd_to_binary_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [9:0] exp_bin = '0;
    logic       exp_ovf = 1'b0;
    logic       exp_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_err"},  32'(bus.err),  0);
        chk({tag, "_bin"},  32'(bus.bin),  0);
        chk({tag, "_ovf"},  32'(bus.bin_ovf), 0);
    endtask

    // Called just after the accepting edge; returns edges counted from E0 up to the done cycle.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic conv(input int h, input int t, input int o, input bit scramble, input string tag);
        bit ok;
        int v;
        int lat;
        int exp_lat;
        ok = (h <= 9) && (t <= 9) && (o <= 9);
        v  = h * 100 + t * 10 + o;
        if (ok) begin
            exp_bin = 10'(v);
            exp_ovf = (v > 255);
            exp_err = 1'b0;
            exp_lat = 11;
        end else begin
            exp_err = 1'b1;
            exp_lat = 1;
        end
        bus.hundreds = 4'(h);
        bus.tens     = 4'(t);
        bus.ones     = 4'(o);
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (scramble) begin
            bus.hundreds = 4'd9;
            bus.tens     = 4'd9;
            bus.ones     = 4'd9;
        end
        chk({tag, "_busy_rise"}, 32'(bus.busy), 1);
        wait_done(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        chk({tag, "_bin"}, 32'(bus.bin), 32'(exp_bin));
        chk({tag, "_ovf"}, 32'(bus.bin_ovf), 32'(exp_ovf));
        @(posedge clk);
        #1;
        chk({tag, "_done_fall"}, 32'(bus.done), 0);
        chk({tag, "_idle"}, 32'(bus.busy), 0);
    endtask

    initial begin
        int dn;
        int h, t, o;

        bus.start    = 1'b0;
        bus.hundreds = '0;
        bus.tens     = '0;
        bus.ones     = '0;

        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        conv(2, 5, 5, 1'b0, "c255");
        conv(9, 9, 9, 1'b0, "c999");
        conv(0, 0, 0, 1'b0, "c000");

        conv(1, 2, 3, 1'b0, "c123");
        conv(1, 10, 3, 1'b0, "bad_tens");
        conv(0, 4, 5, 1'b0, "c045");

        // Starts at E3 (SHIFT) and E11 (DONE) must be ignored.
        bus.hundreds = 4'd3; bus.tens = 4'd0; bus.ones = 4'd0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.hundreds = 4'd0; bus.tens = 4'd0; bus.ones = 4'd1;
        dn = 0;
        for (int e = 1; e <= 14; e++) begin
            bus.start = (e == 3) || (e == 11);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done === 1'b1) dn++;
        end
        exp_bin = 10'd300; exp_ovf = 1'b1; exp_err = 1'b0;
        chk("busy_ign_done_count", 32'(dn), 1);
        chk("busy_ign_bin", 32'(bus.bin), 32'(exp_bin));
        chk("busy_ign_ovf", 32'(bus.bin_ovf), 32'(exp_ovf));
        chk("busy_ign_idle", 32'(bus.busy), 0);

        // Asynchronous reset in the middle of a conversion.
        bus.hundreds = 4'd5; bus.tens = 4'd1; bus.ones = 4'd2;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        dn = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dn++;
        end
        chk("midrst_no_done", 32'(dn), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_bin = '0; exp_ovf = 1'b0; exp_err = 1'b0;
        @(posedge clk);
        #1;
        conv(0, 7, 7, 1'b0, "c077");

        conv(1, 0, 0, 1'b1, "sample100");

        for (int v = 0; v < 1000; v++) begin
            conv(v / 100, (v / 10) % 10, v % 10, 1'b0, "sweep");
        end

        for (int i = 0; i < 300; i++) begin
            h = $urandom_range(0, 9);
            t = $urandom_range(0, 9);
            o = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0:       h = $urandom_range(10, 15);
                    1:       t = $urandom_range(10, 15);
                    default: o = $urandom_range(10, 15);
                endcase
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            conv(h, t, o, $urandom_range(0, 1) == 1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
